pp_reduce_pipe: RTL and testbench

PP_REDUCE_PIPE -- requirements
Module: pp_reduce_pipe

---
 rtl/fpfma_pkg.sv | 9 +
 rtl/pp_reduce_pipe_csa42.sv | 24 ++
 rtl/pp_reduce_pipe.sv | 137 +++++++++++++
 tb/tb_pp_reduce_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fpfma_pkg.sv
// Shared sizing for the FMA significand datapath: Booth generator,
// partial-product reduction and final adder all take their widths from here.
package fpfma_pkg;

  localparam int SIG_WIDTH = 23;
  localparam int PP_WIDTH  = 2*SIG_WIDTH + 2;
  localparam int NUM_PP    = 12;

endpackage

// File: rtl/pp_reduce_pipe_csa42.sv
// 4:2 carry-save compressor built from two chained 3:2 layers.
// Carry output is pre-shifted; anything shifted past the MSB is dropped (mod 2^WIDTH).
module csa42 #(
  parameter int WIDTH = 48
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] c1;

  always_comb begin
    s1    = a ^ b ^ c;
    c1    = ((a & b) | (a & c) | (b & c)) << 1;
    sum   = s1 ^ c1 ^ d;
    carry = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
  end

endmodule

// File: rtl/pp_reduce_pipe.sv
// Three-stage carry-save reduction of 12 Booth partial products to a sum/carry pair:
// S1 three 4:2 compressors, S2 two 3:2 compressors, S3 one 4:2 compressor.
module pp_reduce_pipe #(
  parameter  int SIG_WIDTH = fpfma_pkg::SIG_WIDTH,
  localparam int PP_WIDTH  = 2*SIG_WIDTH + 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [PP_WIDTH-1:0] pp0,
  input  logic signed [PP_WIDTH-1:0] pp1,
  input  logic signed [PP_WIDTH-1:0] pp2,
  input  logic signed [PP_WIDTH-1:0] pp3,
  input  logic signed [PP_WIDTH-1:0] pp4,
  input  logic signed [PP_WIDTH-1:0] pp5,
  input  logic signed [PP_WIDTH-1:0] pp6,
  input  logic signed [PP_WIDTH-1:0] pp7,
  input  logic signed [PP_WIDTH-1:0] pp8,
  input  logic signed [PP_WIDTH-1:0] pp9,
  input  logic signed [PP_WIDTH-1:0] pp10,
  input  logic signed [PP_WIDTH-1:0] pp11,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PP_WIDTH-1:0]        sum_o,
  output logic [PP_WIDTH-1:0]        carry_o
);

  localparam int NUM_PP = fpfma_pkg::NUM_PP;

  logic [PP_WIDTH-1:0] pp [NUM_PP];
  assign pp = '{pp0, pp1, pp2, pp3, pp4, pp5, pp6, pp7, pp8, pp9, pp10, pp11};

  // Handshake: a transfer happens on a rising edge where valid && ready; ready never
  // looks at valid on the same side. A stage loads when empty or when its successor loads.
  logic v1, v2, v3;
  logic ld1, ld2, ld3;

  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign in_ready  = ld1;
  assign out_valid = v3;

  logic [PP_WIDTH-1:0] c1_sum [3];
  logic [PP_WIDTH-1:0] c1_car [3];
  logic [PP_WIDTH-1:0] s1_sum [3];
  logic [PP_WIDTH-1:0] s1_car [3];

  for (genvar g = 0; g < 3; g++) begin : g_s1
    csa42 #(.WIDTH(PP_WIDTH)) u_csa (
      .a     (pp[4*g]),
      .b     (pp[4*g+1]),
      .c     (pp[4*g+2]),
      .d     (pp[4*g+3]),
      .sum   (c1_sum[g]),
      .carry (c1_car[g])
    );
  end

  logic [PP_WIDTH-1:0] c2_sum [2];
  logic [PP_WIDTH-1:0] c2_car [2];
  logic [PP_WIDTH-1:0] s2_sum [2];
  logic [PP_WIDTH-1:0] s2_car [2];

  always_comb begin
    c2_sum[0] = s1_sum[0] ^ s1_car[0] ^ s1_sum[1];
    c2_car[0] = ((s1_sum[0] & s1_car[0]) | (s1_sum[0] & s1_sum[1]) |
                 (s1_car[0] & s1_sum[1])) << 1;
    c2_sum[1] = s1_car[1] ^ s1_sum[2] ^ s1_car[2];
    c2_car[1] = ((s1_car[1] & s1_sum[2]) | (s1_car[1] & s1_car[2]) |
                 (s1_sum[2] & s1_car[2])) << 1;
  end

  logic [PP_WIDTH-1:0] c3_sum;
  logic [PP_WIDTH-1:0] c3_car;

  csa42 #(.WIDTH(PP_WIDTH)) u_s3 (
    .a     (s2_sum[0]),
    .b     (s2_car[0]),
    .c     (s2_sum[1]),
    .d     (s2_car[1]),
    .sum   (c3_sum),
    .carry (c3_car)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        s1_sum[i] <= '0;
        s1_car[i] <= '0;
      end
    end else if (ld1 && in_valid) begin
      for (int i = 0; i < 3; i++) begin
        s1_sum[i] <= c1_sum[i];
        s1_car[i] <= c1_car[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        s2_sum[i] <= '0;
        s2_car[i] <= '0;
      end
    end else if (ld2 && v1) begin
      for (int i = 0; i < 2; i++) begin
        s2_sum[i] <= c2_sum[i];
        s2_car[i] <= c2_car[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_o   <= '0;
      carry_o <= '0;
    end else if (ld3 && v2) begin
      sum_o   <= c3_sum;
      carry_o <= c3_car;
    end
  end

endmodule

// File: tb/tb_pp_reduce_pipe.sv
// Bench for pp_reduce_pipe: directed corner cases plus randomized Booth-encoded
// products, scored against plain arithmetic sums / a*b kept in an expected queue.
module tb_pp_reduce_pipe;

  localparam int W      = 48;
  localparam int NPP    = 12;
  localparam int N_RAND = 10000;
  localparam int BUDGET = 60000;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic signed [W-1:0] pp [NPP];
  logic [W-1:0] nxt_pp [NPP];
  logic [W-1:0] sum_o;
  logic [W-1:0] carry_o;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #5 clk = ~clk;

  pp_reduce_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pp0       (pp[0]),
    .pp1       (pp[1]),
    .pp2       (pp[2]),
    .pp3       (pp[3]),
    .pp4       (pp[4]),
    .pp5       (pp[5]),
    .pp6       (pp[6]),
    .pp7       (pp[7]),
    .pp8       (pp[8]),
    .pp9       (pp[9]),
    .pp10      (pp[10]),
    .pp11      (pp[11]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_o     (sum_o),
    .carry_o   (carry_o)
  );

  function automatic logic [W-1:0] res_now();
    return sum_o + carry_o;
  endfunction

  function automatic logic [W-1:0] pp_total();
    logic [W-1:0] s = '0;
    for (int i = 0; i < NPP; i++) s = s + nxt_pp[i];
    return s;
  endfunction

  // driver: present next inputs just after a falling edge, settle, return before rising edge
  task automatic step(input logic v, input logic r);
    @(negedge clk);
    for (int i = 0; i < NPP; i++) pp[i] = nxt_pp[i];
    in_valid  = v;
    out_ready = r;
    #1;
  endtask

  // radix-4 modified Booth producer for signed 24-bit operands
  task automatic load_booth(input logic signed [23:0] a, input logic signed [23:0] b);
    logic [24:0] bx;
    longint av;
    longint p;
    int d;
    bx = {b, 1'b0};
    av = a;
    for (int k = 0; k < NPP; k++) begin
      d = -2 * int'(bx[2*k+2]) + int'(bx[2*k+1]) + int'(bx[2*k]);
      p = (av * longint'(d)) <<< (2*k);
      nxt_pp[k] = p[W-1:0];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < NPP; i++) begin
      nxt_pp[i] = '0;
      pp[i] = '0;
    end
    #3;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (sum_o !== '0) begin n_fail++; $display("FAIL reset_sum got %h want 0", sum_o); end
    n_tests++; if (carry_o !== '0) begin n_fail++; $display("FAIL reset_carry got %h want 0", carry_o); end
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_held_out_valid got %b want 0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_zero_latency();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NPP; i++) begin
      nxt_pp[i] = '0;
      pp[i] = '0;
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL first_edge_in_ready got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      n_tests++;
      if (out_valid !== (i == 2)) begin
        n_fail++; $display("FAIL latency_out_valid cycle %0d got %b want %b", i + 1, out_valid, (i == 2));
      end
    end
    n_tests++; if (res_now() !== '0) begin n_fail++; $display("FAIL zero_result got %h want 0", res_now()); end
  endtask

  task automatic test_directed();
    logic [W-1:0] e;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NPP; k++) nxt_pp[k] = (p == 0) ? W'(k + 1) : '1;
      e = (p == 0) ? 48'h0000_0000_004E : 48'hFFFF_FFFF_FFF4;
      step(1'b1, 1'b1);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL directed%0d_in_ready got %b want 1", p, in_ready); end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL directed%0d_out_valid got %b want 1", p, out_valid); end
      n_tests++; if (res_now() !== e) begin n_fail++; $display("FAIL directed%0d_result got %h want %h", p, res_now(), e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) for (int k = 0; k < NPP; k++) nxt_pp[k] = W'({$urandom, $urandom});
      step(i < 6, 1'b1);
      if (i < 6) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", i, in_ready); end
      end
      if (in_valid && in_ready) exp_q.push_back(pp_total());
      if (i >= 3) begin
        n_tests++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_out_valid cycle %0d got %b want 1", i, out_valid);
        end else begin
          e = exp_q.pop_front();
          if (res_now() !== e) begin n_fail++; $display("FAIL b2b_result cycle %0d got %h want %h", i, res_now(), e); end
        end
      end
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover got %0d want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < NPP; k++) nxt_pp[k] = '0;
    for (int t = 1; t <= 4; t++) begin
      nxt_pp[0] = W'(t);
      step(1'b1, 1'b0);
      n_tests++;
      if (in_ready !== (t < 4)) begin n_fail++; $display("FAIL bp_in_ready tag %0d got %b want %b", t, in_ready, (t < 4)); end
    end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_full_out_valid got %b want 1", out_valid); end
    step(1'b1, 1'b1);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
    for (int t = 1; t <= 4; t++) begin
      if (t > 1) step(1'b0, 1'b1);
      n_tests++;
      if (out_valid !== 1'b1 || res_now() !== W'(t)) begin
        n_fail++; $display("FAIL bp_order got valid=%b value=%0d want valid=1 value=%0d", out_valid, res_now(), t);
      end
    end
    step(1'b0, 1'b1);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_duplicate got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_random_booth();
    int sent = 0;
    int got = 0;
    int cycles = 0;
    logic pend = 1'b0;
    logic [W-1:0] pend_exp = '0;
    logic [W-1:0] e;
    logic signed [23:0] a;
    logic signed [23:0] b;
    longint prod;
    while (got < N_RAND && cycles < BUDGET) begin
      if (!pend && sent < N_RAND && $urandom_range(0, 3) != 0) begin
        a = 24'($urandom);
        b = 24'($urandom);
        load_booth(a, b);
        prod = longint'(a) * longint'(b);
        pend_exp = prod[W-1:0];
        pend = 1'b1;
      end
      step(pend, $urandom_range(0, 3) != 0);
      if (in_valid && in_ready) begin
        exp_q.push_back(pend_exp);
        pend = 1'b0;
        sent++;
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious got %h want no result", res_now());
        end else begin
          e = exp_q.pop_front();
          if (res_now() !== e) begin n_fail++; $display("FAIL rand_product #%0d got %h want %h", got, res_now(), e); end
        end
        got++;
      end
      cycles++;
    end
    n_tests++; if (got != N_RAND) begin n_fail++; $display("FAIL rand_timeout got %0d results want %0d", got, N_RAND); end
    exp_q.delete();
  endtask

  task automatic test_reset_midflight();
    for (int t = 1; t <= 3; t++) begin
      for (int k = 0; k < NPP; k++) nxt_pp[k] = W'(t * 100 + k);
      step(1'b1, 1'b0);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_fill_in_ready tag %0d got %b want 1", t, in_ready); end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_in_ready got %b want 1", in_ready); end
    n_tests++; if (sum_o !== '0 || carry_o !== '0) begin n_fail++; $display("FAIL mid_rst_data got %h/%h want 0/0", sum_o, carry_o); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale cycle %0d got out_valid %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random_booth();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
